// File: rtl/fire_expand_mac_engine_if.sv
// Streaming bus of the fire7 expand engine: pixel/kernel/bias inputs on one side,
// weight ROM address, sample/finish strobes and the output pixel on the other.
interface fire_expand_mac_engine_if #(
    parameter int DSP_NO = 192,
    parameter int WIDTH  = 16,
    parameter int AW     = 6
);
    logic                        en_i;
    logic [WIDTH-1:0]            ifm_i;
    logic                        ram_feedback;
    logic [DSP_NO*WIDTH-1:0]     kernels_i;
    logic [DSP_NO*2*WIDTH-1:0]   bias_i;
    logic [AW-1:0]               weight_addr;
    logic                        sample;
    logic                        finish;
    logic [DSP_NO*WIDTH-1:0]     ofm;

    modport master (
        output en_i,
        output ifm_i,
        output ram_feedback,
        output kernels_i,
        output bias_i,
        input  weight_addr,
        input  sample,
        input  finish,
        input  ofm
    );

    modport slave (
        input  en_i,
        input  ifm_i,
        input  ram_feedback,
        input  kernels_i,
        input  bias_i,
        output weight_addr,
        output sample,
        output finish,
        output ofm
    );
endinterface

// File: rtl/fire_expand_mac_engine.sv
// 1x1-conv expand engine: DSP_NO signed MAC lanes share one streamed pixel, each output
// pixel is a CHIN-term dot product plus bias, then ReLU and Q14 requantisation.
module fire_expand_mac_engine #(
    parameter int WOUT       = 16,
    parameter int DSP_NO     = 192,
    parameter int WIDTH      = 16,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fire_expand_mac_engine_if.slave bus
);
    localparam int N      = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int AW     = (N > 1) ? $clog2(N) : 1;
    localparam int CW     = $clog2(N + 1);
    localparam int PIXELS = WOUT * WOUT;
    localparam int TW     = $clog2(PIXELS + 1);
    localparam int ACCW   = 2 * WIDTH;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_WRAP = CW'(N);
    localparam logic [TW-1:0] TMR_LAST = TW'(PIXELS - 1);

    logic                    en_r;
    logic [WIDTH-1:0]        ifm_r;
    logic [CW-1:0]           cnt_r;
    logic                    rom_clr_r;
    logic [AW-1:0]           addr_r;
    logic                    lane_en_r;
    logic                    clr_r;
    logic                    sample_r;
    logic [TW-1:0]           timer_r;
    logic                    end_flag_r;
    logic                    fb_r;
    logic [WIDTH-1:0]        kernel_r [DSP_NO];
    logic [ACCW-1:0]         acc_r    [DSP_NO];
    logic [DSP_NO*WIDTH-1:0] ofm_r;

    logic [ACCW-1:0]         prod_s   [DSP_NO];
    logic [ACCW-1:0]         sum_s    [DSP_NO];
    logic [WIDTH-1:0]        q_s      [DSP_NO];
    logic                    unused_bits_s;

    // Per-lane product, biased sum and ReLU + Q14 requantised result.
    always_comb begin
        unused_bits_s = 1'b0;
        for (int i = 0; i < DSP_NO; i++) begin
            // Sign-extend both operands so the low 2*WIDTH bits hold the signed product.
            prod_s[i] = {{WIDTH{ifm_r[WIDTH-1]}}, ifm_r}
                      * {{WIDTH{kernel_r[i][WIDTH-1]}}, kernel_r[i]};
            sum_s[i]  = acc_r[i] + bus.bias_i[i*ACCW +: ACCW];
            if (sum_s[i][ACCW-1]) begin
                q_s[i] = {WIDTH{1'b0}};
            end else begin
                q_s[i] = {1'b0, sum_s[i][WIDTH-2 +: WIDTH-1]};
            end
            unused_bits_s = unused_bits_s ^ (^sum_s[i]);
        end
    end

    // Input staging, per-pixel clear counter, ROM address and end-of-layer tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r       <= 1'b0;
            ifm_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            rom_clr_r  <= 1'b0;
            addr_r     <= {AW{1'b0}};
            lane_en_r  <= 1'b0;
            clr_r      <= 1'b0;
            sample_r   <= 1'b0;
            timer_r    <= {TW{1'b0}};
            end_flag_r <= 1'b0;
            fb_r       <= 1'b0;
        end else begin
            en_r  <= bus.en_i;
            ifm_r <= bus.ifm_i;

            if (en_r && !end_flag_r) begin
                if (cnt_r == CNT_LAST) begin
                    rom_clr_r <= 1'b1;
                    cnt_r     <= CNT_WRAP;
                end else if (cnt_r == CNT_WRAP) begin
                    rom_clr_r <= 1'b0;
                    cnt_r     <= {CW{1'b0}};
                end else begin
                    rom_clr_r <= 1'b0;
                    cnt_r     <= cnt_r + CW'(1'b1);
                end
            end

            if (rom_clr_r) begin
                addr_r <= {AW{1'b0}};
            end else if (en_r) begin
                addr_r <= addr_r + AW'(1'b1);
            end

            lane_en_r <= en_r;
            clr_r     <= rom_clr_r;
            sample_r  <= clr_r;

            // Once the last pixel has been cleared out the timer parks and the layer is over.
            if (timer_r > TMR_LAST) begin
                end_flag_r <= 1'b1;
            end else if (clr_r) begin
                timer_r <= timer_r + TW'(1'b1);
            end

            if (bus.ram_feedback) begin
                fb_r <= 1'b1;
            end
        end
    end

    // Kernel capture, MAC accumulation and output pixel registers for every lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DSP_NO; i++) begin
                kernel_r[i] <= {WIDTH{1'b0}};
                acc_r[i]    <= {ACCW{1'b0}};
            end
            ofm_r <= {(DSP_NO*WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < DSP_NO; i++) begin
                if (en_r) begin
                    kernel_r[i] <= bus.kernels_i[i*WIDTH +: WIDTH];
                end
                if (clr_r) begin
                    acc_r[i]                 <= lane_en_r ? prod_s[i] : {ACCW{1'b0}};
                    ofm_r[i*WIDTH +: WIDTH]  <= q_s[i];
                end else if (lane_en_r) begin
                    acc_r[i] <= acc_r[i] + prod_s[i];
                end
            end
        end
    end

    assign bus.weight_addr = addr_r;
    assign bus.sample      = sample_r;
    assign bus.ofm         = ofm_r;
    assign bus.finish      = end_flag_r & ~fb_r;
endmodule

// File: tb/tb_fire_expand_mac_engine.sv
// Directed bench for fire_expand_mac_engine with DSP_NO=2, CHIN=4, WOUT=2 (5-cycle pixel period,
// 4 pixels per layer); expected values are worked out by hand below.
module tb_fire_expand_mac_engine;
    localparam int DSP_NO = 2;
    localparam int WIDTH  = 16;
    localparam int CHIN   = 4;
    localparam int WOUT   = 2;
    localparam int AW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    fire_expand_mac_engine_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .AW(AW)) bus ();

    fire_expand_mac_engine #(
        .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .CHIN(CHIN), .KERNEL_DIM(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sample(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.sample !== 1'b1 && n < 40);
        check("sample_seen", {31'd0, bus.sample}, 32'd1);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.en_i         = 1'b0;
        bus.ram_feedback = 1'b0;
        tick();
        tick();
        check("rst_ofm",    bus.ofm, 32'd0);
        check("rst_sample", {31'd0, bus.sample}, 32'd0);
        check("rst_finish", {31'd0, bus.finish}, 32'd0);
        check("rst_addr",   {30'd0, bus.weight_addr}, 32'd0);
    endtask

    task automatic check_ofm(input string tag, input logic [15:0] e0, input logic [15:0] e1);
        check({tag, "_ofm0"}, {16'd0, bus.ofm[15:0]},  {16'd0, e0});
        check({tag, "_ofm1"}, {16'd0, bus.ofm[31:16]}, {16'd0, e1});
    endtask

    initial begin
        int n;
        int extra;
        bus.en_i         = 1'b0;
        bus.ifm_i        = 16'h0000;
        bus.ram_feedback = 1'b0;
        bus.kernels_i    = 32'h0000_0000;
        bus.bias_i       = 64'h0000_0000_0000_0000;

        // Single pixel stream: product lane0 = +2^28, lane1 = -2^28.
        do_reset();
        bus.ifm_i     = 16'h4000;
        bus.kernels_i = {16'hC000, 16'h4000};
        rst      = 1'b0;
        bus.en_i = 1'b1;
        repeat (4) tick();
        check("addr_edge4", {30'd0, bus.weight_addr}, 32'd3);
        tick();
        check("addr_wrap", {30'd0, bus.weight_addr}, 32'd0);
        tick();
        check("addr_clr", {30'd0, bus.weight_addr}, 32'd0);
        check("no_early_sample", {31'd0, bus.sample}, 32'd0);
        tick();
        // First pixel holds 4 products = 2^30; bit 30 is dropped so lane0 reads 0.
        check("first_sample", {31'd0, bus.sample}, 32'd1);
        check_ofm("px1", 16'h0000, 16'h0000);
        check("addr_after_clr", {30'd0, bus.weight_addr}, 32'd1);
        tick();
        check("sample_pulse", {31'd0, bus.sample}, 32'd0);
        wait_sample(n);
        check("pixel_period", n + 1, 32'd5);
        // Steady pixels hold 5 products = 0x5000_0000 -> bits 28:14 = 0x4000.
        check_ofm("px2", 16'h4000, 16'h0000);
        wait_sample(n);
        check("pixel_period2", n, 32'd5);
        wait_sample(n);
        check_ofm("px4", 16'h4000, 16'h0000);
        check("finish_before_end", {31'd0, bus.finish}, 32'd0);
        tick();
        check("finish_at_end", {31'd0, bus.finish}, 32'd1);
        extra = 0;
        repeat (12) begin
            tick();
            if (bus.sample === 1'b1) extra++;
        end
        check("no_sample_after_end", extra, 32'd0);
        check("finish_held", {31'd0, bus.finish}, 32'd1);
        bus.ram_feedback = 1'b1;
        tick();
        bus.ram_feedback = 1'b0;
        check("finish_acked", {31'd0, bus.finish}, 32'd0);
        repeat (3) tick();
        check("finish_stays_low", {31'd0, bus.finish}, 32'd0);

        // Bias and ReLU with zero products.
        do_reset();
        bus.ifm_i     = 16'h0000;
        bus.kernels_i = {16'h7FFF, 16'h1234};
        bus.bias_i    = {32'hFFFF_0000, 32'h0000_C000};
        rst      = 1'b0;
        bus.en_i = 1'b1;
        wait_sample(n);
        check("first_latency", n, 32'd7);
        check_ofm("bias", 16'h0003, 16'h0000);

        // Bits 30:29 discarded without saturation.
        do_reset();
        bus.bias_i = {32'h1234_5678, 32'h7000_0000};
        rst      = 1'b0;
        bus.en_i = 1'b1;
        wait_sample(n);
        check_ofm("ovf", 16'h4000, 16'h48D1);

        // Signed mix: lane0 256*512, lane1 256*-256 + 0x0010_0000; early ram_feedback.
        do_reset();
        bus.ifm_i     = 16'h0100;
        bus.kernels_i = {16'hFF00, 16'h0200};
        bus.bias_i    = {32'h0010_0000, 32'h0000_0000};
        rst      = 1'b0;
        bus.en_i = 1'b1;
        tick();
        tick();
        bus.ram_feedback = 1'b1;
        tick();
        bus.ram_feedback = 1'b0;
        wait_sample(n);
        check_ofm("mix1", 16'h0020, 16'h0030);
        wait_sample(n);
        check_ofm("mix2", 16'h0028, 16'h002C);
        wait_sample(n);
        wait_sample(n);
        check_ofm("mix4", 16'h0028, 16'h002C);
        tick();
        tick();
        check("early_fb_no_finish", {31'd0, bus.finish}, 32'd0);

        // Enable gap: lane0 -256*512 + 0x0020_0000, lane1 -256*-256.
        do_reset();
        bus.ifm_i     = 16'hFF00;
        bus.kernels_i = {16'hFF00, 16'h0200};
        bus.bias_i    = {32'h0000_0000, 32'h0020_0000};
        rst      = 1'b0;
        bus.en_i = 1'b1;
        wait_sample(n);
        check_ofm("gap1", 16'h0060, 16'h0010);
        bus.en_i = 1'b0;
        repeat (3) tick();
        check("gap_addr_hold", {30'd0, bus.weight_addr}, 32'd2);
        bus.en_i = 1'b1;
        wait_sample(n);
        check("gap_period", n + 3, 32'd8);
        check_ofm("gap2", 16'h0058, 16'h0014);

        // Reset mid-layer restarts everything from scratch.
        tick();
        tick();
        do_reset();
        rst      = 1'b0;
        bus.en_i = 1'b1;
        wait_sample(n);
        check("restart_latency", n, 32'd7);
        check_ofm("restart", 16'h0060, 16'h0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
